// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with KMP fallback, Mealy/Moore flag and saturating match counter.
// Define SEQDET_PROG_EN to add a runtime-loadable pattern register (pat_wr/pat_in).
module seq_detector_param #(
    parameter int             LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b10101,
    parameter bit             MODE    = 1'b1,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
`ifdef SEQDET_PROG_EN
    input  logic             pat_wr,
    input  logic [LEN-1:0]   pat_in,
`endif
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SW = $clog2(LEN + 1);

    typedef enum logic [SW-1:0] {
        S0      = '0,
        S_MATCH = SW'(LEN)
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LEN-1:0] pat;
    logic [SW-1:0]  post_state;
    logic [SW-1:0]  base_state;
    logic [SW-1:0]  step_state;
    logic           load;
    logic           hit;

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic logic [SW-1:0] advance(input logic [LEN-1:0] p,
                                              input logic [SW-1:0]  k,
                                              input logic           b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= LEN; j++) begin
            if (j <= int'(k) + 1) begin
                ok = 1'b1;
                for (int t = 0; t < LEN; t++) begin
                    if (t < j) begin
                        idx = int'(k) + 1 - j + t;
                        sb  = (idx == int'(k)) ? b : p[LEN-1-idx];
                        if (sb != p[LEN-1-t]) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return SW'(best);
    endfunction

    function automatic logic [SW-1:0] border(input logic [LEN-1:0] p);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < LEN; j++) begin
            ok = 1'b1;
            for (int t = 0; t < LEN; t++) begin
                if (t < j && p[LEN-1-t] != p[j-1-t]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return SW'(best);
    endfunction

`ifdef SEQDET_PROG_EN
    always_ff @(posedge clk) begin
        if (!rst)
            pat <= PATTERN;
        else if (pat_wr)
            pat <= pat_in;
    end

    assign load = pat_wr;
`else
    assign pat  = PATTERN;
    assign load = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S0;
        else
            state <= state_nxt;
    end

    // The match state is only a display state; the next bit is judged from the post-match fallback.
    always_comb begin
        post_state = OVERLAP ? border(pat) : '0;
        base_state = (state == S_MATCH) ? post_state : SW'(state);
        step_state = advance(pat, base_state, din);
        hit        = din_vld && !load && (step_state == SW'(LEN));
        state_nxt  = state;
        if (load)
            state_nxt = S0;
        else if (din_vld) begin
            if (!MODE && hit)
                state_nxt = state_t'(post_state);
            else
                state_nxt = state_t'(step_state);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            match_cnt <= '0;
        else if (hit && match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
    end

    assign flag = MODE ? (state == S_MATCH) : (rst && hit);

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector. Successor to the fixed-pattern Mealy/Moore detectors: pattern, length, output style (Mealy/Moore) and overlap policy are all selectable. Adds an input-valid qualifier and a saturating match counter. Sits directly on a serial bit stream and feeds a pulse flag plus a count to downstream control/status logic.

Parameters:
LEN, 5, pattern length in bits; legal range 2..16.
PATTERN, 5'b10101, pattern to detect, LEN bits wide; PATTERN[LEN-1] is the first bit received.
MODE, 1, 0 = Mealy flag (combinational), 1 = Moore flag (registered, state-decoded).
OVERLAP, 1, 1 = overlapping matches allowed, 0 = non-overlapping.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-low reset, sampled on posedge clk.
din_vld  input  1  din is consumed at a posedge only when this is high.
din  input  1  serial data bit.
flag  output  1  match indication; timing set by MODE.
match_cnt  output  CNT_W  number of matches since reset; saturating.

Behaviour:
- FSM states S0..S(LEN). State k means the last k consumed bits equal the first k bits of the pattern. S(LEN) is the match state and is used in Moore mode only.
- Transitions use KMP-style failure fallback: on a mismatch, move to the longest pattern prefix that is a suffix of the consumed history. The table is derived from PATTERN at elaboration, or from the loaded pattern when the optional feature is enabled.
- After a completed match:
  - OVERLAP=1: next state = longest proper border of the pattern.
  - OVERLAP=0: next state = S0; no bit of the matched sequence is reused.
- din_vld=0: state and counter hold.
- Reset (rst=0 at posedge) takes priority over all other inputs.
  - State -> S0, match_cnt -> 0, registered flag -> 0.
  - Any partial sequence is discarded.
- MODE=0 (Mealy):
  - flag = rst & din_vld & (state==S(LEN-1) or its failure equivalent) & din completes the pattern.
  - flag is high in the same cycle the last bit is presented, with zero latency.
  - flag is 0 whenever din_vld=0 or rst=0.
- MODE=1 (Moore):
  - flag = (state==S(LEN)), so it rises one cycle after the posedge that consumed the last bit.
  - flag stays high until the next valid bit is consumed; it stays high across din_vld=0 bubbles.
  - From S(LEN), the next valid bit is evaluated from the post-match fallback state defined above.
- match_cnt:
  - Increments by 1 at the posedge that consumes a completing bit, in both modes.
  - Holds at 2^CNT_W-1 (no wrap).
  - Reset wins over a simultaneous increment.
- All outputs are driven by clk-domain registers, except the Mealy flag, which is combinational.

Optional Feature:
Macro: SEQDET_PROG_EN.
- Defined: adds two ports:
  - pat_wr  input  1
  - pat_in  input  LEN
- On a posedge with rst=1 and pat_wr=1:
  - The pattern register loads pat_in.
  - State -> S0; Moore flag clears.
  - din in that cycle is ignored, and the Mealy flag is forced to 0 that cycle.
  - match_cnt is unchanged.
- The failure table is recomputed combinationally from the pattern register.
- Reset reloads PATTERN.
- Undefined: the pattern is the constant PATTERN and the ports are absent.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with din_vld=1, din=1 -> flag=0, match_cnt=0; the first bits after release start from S0.
2. MODE=1, OVERLAP=1, PATTERN=10101, bits 1,0,1,0,1,0,1 every cycle -> flag high for one cycle after the 5th and after the 7th bit; match_cnt=2.
3. OVERLAP=0, same stream -> a single match after bit 5, match_cnt=1; appending 0,1,0,1,0,1 -> next flag only after bit 11, match_cnt=2.
4. MODE=0: present 1,0,1, then din_vld=0 for 3 cycles (din toggling), then 0,1 -> flag=1 combinationally only while the final 1 is presented; 0 during bubbles; match_cnt=1.
5. CNT_W=2, stream of 5 non-overlapping matches -> match_cnt reads 1,2,3,3,3.
6. Mid-sequence reset: feed 1,0,1,0, pulse rst=0 for 1 cycle, feed 1 -> no flag, match_cnt=0. With SEQDET_PROG_EN: pat_wr=1, pat_in=11011, then feed 1,1,0,1,1 -> one match, match_cnt increments by 1.
